mod47_bcd_display: RTL and testbench

MOD47_BCD_DISPLAY -- requirements
Module: mod47_bcd_display

---
 rtl/mod47_pkg.sv | 25 ++
 rtl/seg7_decode.sv | 26 ++
 rtl/mod47_bcd_display.sv | 107 ++++++++++
 tb/tb_mod47_bcd_display.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mod47_pkg.sv
// Shared constants for the modulus-47 BCD display: default range, segment
// patterns (gfedcba, active high) and digit-select encodings.
package mod47_pkg;

   localparam logic [7:0] MOD_MAX_DEF = 8'd46;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_DASH  = 7'h40;

   localparam logic [1:0] DIG_UNITS = 2'b01;
   localparam logic [1:0] DIG_TENS  = 2'b10;

   typedef logic [3:0] bcd_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to seven-segment decoder; non-BCD codes render blank.
module seg7_decode
   import mod47_pkg::*;
(
   input  bcd_t       bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/mod47_bcd_display.sv
// Two-digit multiplexed display of a modulus-47 counter, with wrap detection,
// wrap counting and a sticky out-of-range flag.
module mod47_bcd_display
   import mod47_pkg::*;
#(
   parameter logic [15:0] SCAN_DIV = 16'd1000,
   parameter logic [7:0]  MOD_MAX  = MOD_MAX_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] count_in,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       wrap_pulse,
   output logic [7:0] wrap_cnt,
   output logic       err
);

   logic [7:0]  count_q, prev_q, wrap_cnt_q, wrap_cnt_d;
   logic [15:0] presc_q, presc_d;
   logic [1:0]  an_q, an_d;
   logic [6:0]  seg_q, seg_d, dec_seg;
   logic        wrap_q, wrap_d, err_q, err_d, bad;
   bcd_t        tens, units, digit;
   logic [3:0]  sub_lo;

   // Units only need the low nibble: (count - 10*tens) mod 16 is exact for 0..9.
   always_comb begin
      tens   = 4'd0;
      sub_lo = 4'h0;
      if (count_q >= 8'd40) begin
         tens   = 4'd4;
         sub_lo = 4'h8;
      end else if (count_q >= 8'd30) begin
         tens   = 4'd3;
         sub_lo = 4'hE;
      end else if (count_q >= 8'd20) begin
         tens   = 4'd2;
         sub_lo = 4'h4;
      end else if (count_q >= 8'd10) begin
         tens   = 4'd1;
         sub_lo = 4'hA;
      end
      units = count_q[3:0] - sub_lo;
   end

   always_comb begin
      presc_d = presc_q + 16'd1;
      an_d    = an_q;
      if (presc_q == SCAN_DIV - 16'd1) begin
         presc_d = 16'd0;
         an_d    = (an_q == DIG_UNITS) ? DIG_TENS : DIG_UNITS;
      end
   end

   // Select on the next digit so seg and an change on the same edge.
   assign digit = (an_d == DIG_TENS) ? tens : units;

   seg7_decode u_seg7_decode (
      .bcd_i (digit),
      .seg_o (dec_seg)
   );

   assign bad = (count_q > MOD_MAX);

   always_comb begin
      seg_d = dec_seg;
      if (bad) begin
         seg_d = SEG_DASH;
      end else if ((an_d == DIG_TENS) && (tens == 4'd0)) begin
         seg_d = SEG_BLANK;
      end
   end

   assign wrap_d     = (count_q == 8'd0) && (prev_q == MOD_MAX);
   assign wrap_cnt_d = wrap_cnt_q + {7'd0, wrap_d};
   assign err_d      = err_q | bad;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q    <= 8'd0;
         prev_q     <= 8'd0;
         presc_q    <= 16'd0;
         an_q       <= DIG_UNITS;
         seg_q      <= SEG_BLANK;
         wrap_q     <= 1'b0;
         wrap_cnt_q <= 8'd0;
         err_q      <= 1'b0;
      end else begin
         count_q    <= count_in;
         prev_q     <= count_q;
         presc_q    <= presc_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         wrap_q     <= wrap_d;
         wrap_cnt_q <= wrap_cnt_d;
         err_q      <= err_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign wrap_pulse = wrap_q;
   assign wrap_cnt   = wrap_cnt_q;
   assign err        = err_q;

endmodule

// File: tb/tb_mod47_bcd_display.sv
// Directed self-checking bench for mod47_bcd_display with a 4-cycle scan.
module tb_mod47_bcd_display;

   localparam int SD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] count_in = 8'd0;
   logic [6:0] seg;
   logic [1:0] an;
   logic       wrap_pulse;
   logic [7:0] wrap_cnt;
   logic       err;

   int checks = 0;
   int passes = 0;
   int cyc = 0;

   mod47_bcd_display #(
      .SCAN_DIV (16'd4),
      .MOD_MAX  (8'd46)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .count_in   (count_in),
      .seg        (seg),
      .an         (an),
      .wrap_pulse (wrap_pulse),
      .wrap_cnt   (wrap_cnt),
      .err        (err)
   );

   always #5 clk = ~clk;

   // One rising edge, then settle to the falling edge for sampling/driving.
   task automatic step();
      @(posedge clk);
      cyc = rst ? 0 : cyc + 1;
      @(negedge clk);
   endtask

   function automatic logic [1:0] exp_an();
      return (((cyc / SD) % 2) == 1) ? 2'b10 : 2'b01;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      count_in = 8'd37;
      step();
      step();
      checks++; if (seg !== 7'h00) $display("FAIL reset_seg: got %h want 00", seg); else passes++;
      checks++; if (an !== 2'b01) $display("FAIL reset_an: got %b want 01", an); else passes++;
      checks++; if (wrap_pulse !== 1'b0) $display("FAIL reset_wrap: got %b want 0", wrap_pulse); else passes++;
      checks++; if (wrap_cnt !== 8'd0) $display("FAIL reset_wcnt: got %0d want 0", wrap_cnt); else passes++;
      checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passes++;
   endtask

   task automatic test_decode();
      logic [6:0] es;
      rst = 1'b0;
      count_in = 8'd37;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k >= 2) begin
            es = (exp_an() == 2'b10) ? 7'h4F : 7'h07;
            checks++; if (an !== exp_an()) $display("FAIL decode_an k=%0d: got %b want %b", k, an, exp_an()); else passes++;
            checks++; if (seg !== es) $display("FAIL decode_seg k=%0d: got %h want %h", k, seg, es); else passes++;
         end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] seq [5] = '{8'd45, 8'd46, 8'd0, 8'd1, 8'd2};
      logic       ew  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [7:0] ec  [5] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1};
      for (int i = 0; i < 5; i++) begin
         count_in = seq[i];
         step();
         checks++; if (wrap_pulse !== ew[i]) $display("FAIL wrap_pulse i=%0d: got %b want %b", i, wrap_pulse, ew[i]); else passes++;
         checks++; if (wrap_cnt !== ec[i]) $display("FAIL wrap_cnt i=%0d: got %0d want %0d", i, wrap_cnt, ec[i]); else passes++;
      end
   endtask

   task automatic test_nonwrap();
      logic [6:0] es;
      count_in = 8'd20;
      step();
      count_in = 8'd0;
      for (int i = 0; i < 12; i++) begin
         step();
         checks++; if (wrap_pulse !== 1'b0) $display("FAIL nonwrap_pulse i=%0d: got %b want 0", i, wrap_pulse); else passes++;
         if (i >= 2) begin
            es = (exp_an() == 2'b10) ? 7'h00 : 7'h3F;
            checks++; if (seg !== es) $display("FAIL blank_seg i=%0d: got %h want %h", i, seg, es); else passes++;
         end
      end
      checks++; if (wrap_cnt !== 8'd1) $display("FAIL nonwrap_cnt: got %0d want 1", wrap_cnt); else passes++;
   endtask

   task automatic test_error();
      logic [6:0] es;
      count_in = 8'd47;
      step();
      checks++; if (err !== 1'b0) $display("FAIL err_early: got %b want 0", err); else passes++;
      count_in = 8'd5;
      step();
      checks++; if (seg !== 7'h40) $display("FAIL err_dash: got %h want 40", seg); else passes++;
      checks++; if (err !== 1'b1) $display("FAIL err_set: got %b want 1", err); else passes++;
      for (int i = 0; i < 10; i++) begin
         step();
         es = (exp_an() == 2'b10) ? 7'h00 : 7'h6D;
         checks++; if (err !== 1'b1) $display("FAIL err_sticky i=%0d: got %b want 1", i, err); else passes++;
         checks++; if (seg !== es) $display("FAIL err_after_seg i=%0d: got %h want %h", i, seg, es); else passes++;
      end
   endtask

   task automatic test_rollover();
      int pulses = 0;
      rst = 1'b1;
      count_in = 8'd0;
      step();
      rst = 1'b0;
      for (int r = 0; r < 256; r++) begin
         for (int v = 0; v <= 46; v++) begin
            count_in = v[7:0];
            step();
            if (wrap_pulse === 1'b1) begin
               pulses++;
               checks++; if (wrap_cnt !== pulses[7:0]) $display("FAIL roll_cnt p=%0d: got %0d want %0d", pulses, wrap_cnt, pulses[7:0]); else passes++;
            end
         end
      end
      count_in = 8'd0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (wrap_pulse === 1'b1) pulses++;
      end
      checks++; if (pulses != 256) $display("FAIL roll_pulses: got %0d want 256", pulses); else passes++;
      checks++; if (wrap_cnt !== 8'd0) $display("FAIL roll_final: got %0d want 0", wrap_cnt); else passes++;
   endtask

   task automatic test_mid_reset();
      count_in = 8'd1;
      step();
      step();
      count_in = 8'd46;
      step();
      count_in = 8'd0;
      step();
      // A wrap pulse is pending on the next edge; reset must abort it.
      rst = 1'b1;
      count_in = 8'd46;
      step();
      checks++; if (seg !== 7'h00) $display("FAIL mrst_seg: got %h want 00", seg); else passes++;
      checks++; if (an !== 2'b01) $display("FAIL mrst_an: got %b want 01", an); else passes++;
      checks++; if (wrap_pulse !== 1'b0) $display("FAIL mrst_wrap: got %b want 0", wrap_pulse); else passes++;
      checks++; if (wrap_cnt !== 8'd0) $display("FAIL mrst_wcnt: got %0d want 0", wrap_cnt); else passes++;
      checks++; if (err !== 1'b0) $display("FAIL mrst_err: got %b want 0", err); else passes++;
      rst = 1'b0;
      count_in = 8'd0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (wrap_pulse !== 1'b0) $display("FAIL mrst_nowrap i=%0d: got %b want 0", i, wrap_pulse); else passes++;
      end
      checks++; if (wrap_cnt !== 8'd0) $display("FAIL mrst_cnt_after: got %0d want 0", wrap_cnt); else passes++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq [8] = '{8'd46, 8'd0, 8'd46, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      int pulses = 0;
      for (int i = 0; i < 8; i++) begin
         count_in = seq[i];
         step();
         if (wrap_pulse === 1'b1) pulses++;
      end
      checks++; if (pulses != 2) $display("FAIL b2b_pulses: got %0d want 2", pulses); else passes++;
      checks++; if (wrap_cnt !== 8'd2) $display("FAIL b2b_cnt: got %0d want 2", wrap_cnt); else passes++;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_decode();
      test_wrap();
      test_nonwrap();
      test_error();
      test_rollover();
      test_mid_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
